// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise logic unit with a 2-entry
// (main + skid) output buffer and a saturating operand-equality counter.

// One bit-lane of the logic function; replicated WIDTH times by the top.
module logic_unit_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    // Select one of the eight two-operand functions for this bit.
    always_comb begin
        y = a;
        case (op)
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b010: y = a ^ b;
            3'b011: y = ~(a ^ b);
            3'b100: y = ~(a & b);
            3'b101: y = ~(a | b);
            3'b110: y = ~a;
            3'b111: y = a;
            default: y = a;
        endcase
    end
endmodule

module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic [CNT_W-1:0] eq_cnt,
    input  logic             cnt_clr
);
    // One buffered result: data word, its all-ones flag, and occupancy.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             all;
        logic             vld;
    } entry_t;

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           new_e;
    logic [WIDTH-1:0] res_c;
    logic             in_acc;
    logic             out_acc;
    logic [CNT_W-1:0] cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic_unit_lane u_lane (
                .op (op),
                .a  (a[gi]),
                .b  (b[gi]),
                .y  (res_c[gi])
            );
        end
    endgenerate

    // Ready depends only on the skid register, so downstream stalls never
    // reach in_ready combinationally.
    assign in_ready  = ~skid_q.vld;
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = main_q.vld & out_ready;
    assign out_valid = main_q.vld;
    assign y         = main_q.res;
    assign y_all     = main_q.all;
    assign eq_cnt    = cnt_q;

    // Entry built from this cycle's operands.
    always_comb begin
        new_e     = '0;
        new_e.res = res_c;
        new_e.all = &res_c;
        new_e.vld = 1'b1;
    end

    // Buffer next state: skid always refills main before new data so
    // results leave in acceptance order.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!main_q.vld) begin
            if (in_acc) main_d = new_e;
        end else if (out_acc) begin
            if (skid_q.vld) begin
                main_d     = skid_q;
                skid_d.vld = 1'b0;
            end else if (in_acc) begin
                main_d = new_e;
            end else begin
                main_d.vld = 1'b0;
            end
        end else if (in_acc) begin
            skid_d = new_e;
        end
    end

    // Buffer registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Saturating count of accepted identical operand pairs; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (in_acc && (a == b) && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule
